// File: rtl/fa_serial_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// The optional signed-overflow output is enabled with FA_SERIAL_OVF_EN.
package fa_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN cycles per operation; guarded so a bad DIGIT reaches the
    // elaboration check instead of a divide-by-zero.
    function automatic int cycles(input int width, input int digit);
        return (digit > 0) ? (width / digit) : 1;
    endfunction

    // Counter must hold CYCLES itself so it never wraps inside an operation.
    function automatic int cnt_width(input int n_cycles);
        return (n_cycles < 1) ? 1 : $clog2(n_cycles + 1);
    endfunction

endpackage

// File: rtl/fa_digit.sv
// One digit slice of the serial adder: a combinational ripple of DIGIT
// full-adder cells, also exposing the carry into the top bit for overflow.
module fa_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa_x1
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/fa_serial_adder.sv
// Digit-serial adder: WIDTH-bit a + b + ci over WIDTH/DIGIT cycles with
// valid/ready handshakes. Define FA_SERIAL_OVF_EN to add the ovf output.
module fa_serial_adder
    import fa_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef FA_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CYCLES = cycles(WIDTH, DIGIT);
    localparam int CNT_W  = cnt_width(CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("fa_serial_adder: DIGIT must divide WIDTH and satisfy 1 <= DIGIT <= WIDTH");
    end

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [DIGIT-1:0] d_sum;
    logic             d_co;
    logic             d_cmsb;
    logic             last_step;
    logic [WIDTH-1:0] sum_shift;

    fa_digit #(.DIGIT(DIGIT)) u_digit (
        .a     (sa[DIGIT-1:0]),
        .b     (sb[DIGIT-1:0]),
        .ci    (carry),
        .sum   (d_sum),
        .co    (d_co),
        .c_msb (d_cmsb)
    );

    assign last_step = (state == RUN) && (cnt == LAST);
    assign in_ready  = (state == IDLE);

    // Each new digit enters at the MSB end; after CYCLES steps the first
    // digit has reached bit 0. Works unchanged when DIGIT == WIDTH.
    assign sum_shift = (sum >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)  next_state = RUN;
            RUN:     if (cnt == LAST) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa        <= '0;
            sb        <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            co        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= ci;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sa    <= sa >> DIGIT;
                    sb    <= sb >> DIGIT;
                    sum   <= sum_shift;
                    carry <= d_co;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_step) begin
                        co        <= d_co;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FA_SERIAL_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last_step) begin
            ovf <= d_cmsb ^ d_co;
        end
    end
`else
    logic unused_cmsb;
    assign unused_cmsb = d_cmsb;
`endif

endmodule

// File: tb/tb_fa_serial_adder.sv
// Directed self-checking bench for fa_serial_adder (16/4 instance) plus
// exhaustive 3-bit runs with DIGIT=1 and DIGIT=3 under random backpressure.
module tb_fa_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid, in_ready, ci, out_valid, out_ready, co;
    logic [15:0] a, b, sum;
    logic        ovf;

    logic       in_valid3, ci3;
    logic [2:0] a3, b3;
    logic       in_ready_s, out_valid_s, out_ready_s, co_s, ovf_s;
    logic       in_ready_p, out_valid_p, out_ready_p, co_p, ovf_p;
    logic [2:0] sum_s, sum_p;

    int checks = 0;
    int errors = 0;

    fa_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co)
`ifdef FA_SERIAL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    fa_serial_adder #(.WIDTH(3), .DIGIT(1)) u_dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid3),
        .in_ready  (in_ready_s),
        .a         (a3),
        .b         (b3),
        .ci        (ci3),
        .out_valid (out_valid_s),
        .out_ready (out_ready_s),
        .sum       (sum_s),
        .co        (co_s)
`ifdef FA_SERIAL_OVF_EN
        ,
        .ovf       (ovf_s)
`endif
    );

    fa_serial_adder #(.WIDTH(3), .DIGIT(3)) u_dut_p (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid3),
        .in_ready  (in_ready_p),
        .a         (a3),
        .b         (b3),
        .ci        (ci3),
        .out_valid (out_valid_p),
        .out_ready (out_ready_p),
        .sum       (sum_p),
        .co        (co_p)
`ifdef FA_SERIAL_OVF_EN
        ,
        .ovf       (ovf_p)
`endif
    );

`ifndef FA_SERIAL_OVF_EN
    assign ovf   = 1'b0;
    assign ovf_s = 1'b0;
    assign ovf_p = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one operand set and wait (bounded) for out_valid.
    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic civ,
                        output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        ci       = civ;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake16();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int         lat;
        logic [3:0] res_s, res_p, exp3;
        logic       ov_s, ov_p, exp_ov3;
        logic       done_s, done_p;
        int         guard;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        ci          = 1'b0;
        in_valid3   = 1'b0;
        a3          = '0;
        b3          = '0;
        ci3         = 1'b0;
        out_ready_s = 1'b0;
        out_ready_p = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_co",        32'(co),        32'd0);
`ifdef FA_SERIAL_OVF_EN
        check("rst_ovf",       32'(ovf),       32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'hABCD, 16'h5433, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{16'h1357, 16'h2468, 1'b1, 16'h37C0, 1'b0, 1'b0};

        for (int i = 0; i < 5; i++) begin
            op16(vecs[i].a, vecs[i].b, vecs[i].ci, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("v%0d_sum", i),     32'(sum), 32'(vecs[i].s));
            check($sformatf("v%0d_co", i),      32'(co),  32'(vecs[i].co));
`ifdef FA_SERIAL_OVF_EN
            check($sformatf("v%0d_ovf", i),     32'(ovf), 32'(vecs[i].ovf));
`endif
            check($sformatf("v%0d_in_ready_done", i), 32'(in_ready), 32'd0);
            handshake16();
            check($sformatf("v%0d_in_ready_after", i),  32'(in_ready),  32'd1);
            check($sformatf("v%0d_out_valid_after", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: result must hold while in_valid and operands toggle.
        op16(16'h8000, 16'h8000, 1'b0, lat);
        check("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 6; i++) begin
            in_valid = ~in_valid;
            a        = 16'($urandom);
            b        = 16'($urandom);
            ci       = 1'($urandom);
            @(posedge clk); #1;
            check($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_sum", i),       32'(sum),       32'h0000);
            check($sformatf("bp%0d_co", i),        32'(co),        32'd1);
            check($sformatf("bp%0d_in_ready", i),  32'(in_ready),  32'd0);
`ifdef FA_SERIAL_OVF_EN
            check($sformatf("bp%0d_ovf", i),       32'(ovf),       32'd1);
`endif
        end
        in_valid = 1'b0;
        handshake16();
        check("bp_in_ready_after",  32'(in_ready),  32'd1);
        check("bp_out_valid_after", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("bp_still_idle", 32'(in_ready), 32'd1);

        // Reset during the second RUN cycle discards the operation.
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        ci       = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum",       32'(sum),       32'd0);
        check("midrst_co",        32'(co),        32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op16(16'h1234, 16'h4321, 1'b0, lat);
        check("after_rst_latency", 32'(lat), 32'd4);
        check("after_rst_sum",     32'(sum), 32'h5555);
        check("after_rst_co",      32'(co),  32'd0);
        handshake16();

        // Exhaustive 3-bit, bit-serial and single-digit instances in lockstep.
        for (int i = 0; i < 128; i++) begin
            a3  = i[2:0];
            b3  = i[5:3];
            ci3 = i[6];
            exp3    = 4'({1'b0, a3} + {1'b0, b3} + {3'b000, ci3});
            exp_ov3 = (a3[2] == b3[2]) && (exp3[2] != a3[2]);
            res_s   = 'x;
            res_p   = 'x;
            ov_s    = 1'bx;
            ov_p    = 1'bx;
            in_valid3 = 1'b1;
            @(posedge clk); #1;
            in_valid3 = 1'b0;
            done_s = 1'b0;
            done_p = 1'b0;
            guard  = 0;
            while (!(done_s && done_p) && guard < 40) begin
                out_ready_s = 1'($urandom_range(0, 1));
                out_ready_p = 1'($urandom_range(0, 1));
                #1;
                if (out_valid_s && out_ready_s && !done_s) begin
                    res_s  = {co_s, sum_s};
                    ov_s   = ovf_s;
                    done_s = 1'b1;
                end
                if (out_valid_p && out_ready_p && !done_p) begin
                    res_p  = {co_p, sum_p};
                    ov_p   = ovf_p;
                    done_p = 1'b1;
                end
                @(posedge clk); #1;
                guard++;
            end
            out_ready_s = 1'b0;
            out_ready_p = 1'b0;
            check($sformatf("w3d1_%0d_result", i), 32'(res_s), 32'(exp3));
            check($sformatf("w3d3_%0d_result", i), 32'(res_p), 32'(exp3));
            check($sformatf("w3_%0d_idle", i), 32'({in_ready_s, in_ready_p}), 32'd3);
`ifdef FA_SERIAL_OVF_EN
            check($sformatf("w3d1_%0d_ovf", i), 32'(ov_s), 32'(exp_ov3));
            check($sformatf("w3d3_%0d_ovf", i), 32'(ov_p), 32'(exp_ov3));
`else
            if (ov_s !== 1'b0 || ov_p !== 1'b0 || exp_ov3 === 1'bx) begin
                check($sformatf("w3_%0d_ovf_tieoff", i), 32'({ov_s, ov_p}), 32'd0);
            end
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fa_serial_adder.md
# fa_serial_adder

Parametrised digit-serial adder built from a chain of full-adder cells. It adds two WIDTH-bit operands plus a carry-in over WIDTH/DIGIT clock cycles. It processes DIGIT bits per cycle and keeps the carry in a register between cycles. Operands are accepted, and results returned, through valid/ready handshakes. It sits in the datapath library as the area-saving alternative to a full-width ripple adder.

## Interface
- WIDTH, 16: operand and sum width in bits.
- DIGIT, 4: bits added per cycle. Constraint: WIDTH % DIGIT == 0 and 1 <= DIGIT <= WIDTH. Elaboration fails otherwise.
- clk  in  1  clock. All state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand presented.
- in_ready  out  1  block can accept operands. Equal to (state == IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  a + b + ci, modulo 2^WIDTH.
- co  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow. Present only with FA_SERIAL_OVF_EN.

## Operation
- CYCLES = WIDTH/DIGIT.
- States:
  - IDLE: in_ready = 1. When in_valid is high, the edge loads shift registers sa <= a and sb <= b, sets carry <= ci, clears cnt <= 0 and moves to RUN.
  - RUN: each edge feeds sa[DIGIT-1:0], sb[DIGIT-1:0] and carry into the digit adder. Both operand registers shift right by DIGIT. The digit result shifts into the result register from the MSB end. carry <= digit carry-out and cnt <= cnt+1. On the edge where cnt == CYCLES-1, the state moves to DONE and co takes the final carry.
  - DONE: out_valid = 1. sum, co and ovf are held stable. When out_ready is high, the edge moves to IDLE.
- in_valid is ignored outside IDLE. a, b and ci are sampled only on the accept edge.
- cnt is ceil(log2(CYCLES+1)) bits wide and never wraps within an operation.
- Arithmetic is unsigned. The carry chain is exactly DIGIT full-adder cells per cycle.
- Reset, including mid-RUN or mid-DONE: state goes to IDLE and the operation is discarded.
- Reset values: out_valid=0, sum=0, co=0, ovf=0, cnt=0, carry=0. in_ready=1, because IDLE is the reset state.

## Timing
- Accept edge E0. out_valid rises after edge E0+CYCLES, which is CYCLES cycles of latency.
- With out_ready held high, the result handshake occurs on E0+CYCLES+1. in_ready is high again after that edge.
- Throughput: one operation per CYCLES+2 cycles.
- DIGIT == WIDTH: CYCLES = 1, so a single RUN cycle.
- DIGIT == 1: bit-serial operation, WIDTH RUN cycles.
- Outputs are registered except in_ready, which is a decode of the state register.

## Configuration
- FA_SERIAL_OVF_EN defined:
  - The ovf port exists.
  - ovf = (carry into bit WIDTH-1) XOR co, captured on the final RUN edge.
  - ovf is held in DONE and cleared by reset.
- FA_SERIAL_OVF_EN undefined: no ovf port and no extra register. All other behaviour is identical.

## Structure
- Package fa_serial_pkg:
  - state typedef {IDLE, RUN, DONE}, 2 bits.
  - function cycles(WIDTH, DIGIT).
  - function for the cnt width.
- Sub-module fa_digit:
  - Parameter DIGIT.
  - Combinational ripple of DIGIT FA_X1 instances.
  - Outputs: the digit sum, co, and c_msb (carry into the top bit, used for ovf).
- The top level contains the FSM, counter and shift registers.

## Test plan
All scenarios use WIDTH=16, DIGIT=4 unless stated.
- a=0, b=0, ci=0 -> sum=16'h0000, co=0. out_valid rises exactly 4 cycles after the accept edge.
- a=16'hFFFF, b=16'h0000, ci=1 -> sum=16'h0000, co=1. The carry propagates across all 4 digits.
- a=16'h7FFF, b=16'h0001, ci=0 -> sum=16'h8000, co=0. ovf=1 with the macro defined.
- Hold out_ready=0 for 6 cycles in DONE while toggling in_valid and a/b -> sum, co and out_valid are stable, in_ready=0, and no new operand is accepted.
- rst_n low during the 2nd RUN cycle -> out_valid=0 and sum=0 immediately, in_ready=1. The next operation, a=16'h1234, b=16'h4321, ci=0, gives sum=16'h5555.
- Run WIDTH=3 with DIGIT=1 and with DIGIT=3, exhaustively over all 128 combinations of a, b and ci -> {co,sum} == a+b+ci for every case, with randomised out_ready backpressure.
